// File: rtl/fpu_status_pkg.sv
// Shared definitions for the FPU status unit: exception bit indices,
// status-word field positions and the interrupt FSM state encoding.
package fpu_status_pkg;

    // Exception flag indices (same order as exc_in and ctrl_mask)
    localparam int EXC_IE = 0;
    localparam int EXC_DE = 1;
    localparam int EXC_ZE = 2;
    localparam int EXC_OE = 3;
    localparam int EXC_UE = 4;
    localparam int EXC_PE = 5;
    localparam int EXC_N  = 6;

    // Status-word fields below the TOP field are fixed in position
    localparam int SW_IE      = 0;
    localparam int SW_PE      = 5;
    localparam int SW_SF      = 6;
    localparam int SW_ES      = 7;
    localparam int SW_C0      = 8;
    localparam int SW_C1      = 9;
    localparam int SW_C2      = 10;
    localparam int SW_TOP_LSB = 11;

    // C3 and B sit above TOP, so their position follows the pointer width
    function automatic int sw_c3_pos(input int ptr_w);
        return SW_TOP_LSB + ptr_w;
    endfunction

    function automatic int sw_b_pos(input int ptr_w);
        return SW_TOP_LSB + ptr_w + 1;
    endfunction

    // Interrupt request FSM states
    typedef enum logic [1:0] {
        IRQ_IDLE     = 2'd0,
        IRQ_ASSERT   = 2'd1,
        IRQ_WAIT_CLR = 2'd2
    } irq_state_e;

endpackage

// File: rtl/fpu_status_unit_if.sv
// Control/status bundle between the FPU core and its status unit.
// The master side is the core driving updates; the slave side is the
// status unit returning the status word, top pointer and interrupt.
interface fpu_status_unit_if #(
    parameter int PTR_W = 3
) ();
    localparam int SW_W = 13 + PTR_W;

    logic             top_inc;
    logic             top_dec;
    logic             top_load;
    logic [PTR_W-1:0] top_load_val;
    logic             cc_write;
    logic [3:0]       cc_in;
    logic             exc_valid;
    logic [5:0]       exc_in;
    logic             stack_fault_in;
    logic             sf_overflow;
    logic [5:0]       ctrl_mask;
    logic             clear_exceptions;
    logic             sw_load;
    logic [SW_W-1:0]  sw_load_val;
    logic             set_busy;
    logic             clear_busy;
    logic             irq_ack;
    logic [SW_W-1:0]  status_word;
    logic [PTR_W-1:0] top;
    logic             irq;

    modport master (
        output top_inc, top_dec, top_load, top_load_val,
        output cc_write, cc_in,
        output exc_valid, exc_in, stack_fault_in, sf_overflow,
        output ctrl_mask, clear_exceptions,
        output sw_load, sw_load_val,
        output set_busy, clear_busy, irq_ack,
        input  status_word, top, irq
    );

    modport slave (
        input  top_inc, top_dec, top_load, top_load_val,
        input  cc_write, cc_in,
        input  exc_valid, exc_in, stack_fault_in, sf_overflow,
        input  ctrl_mask, clear_exceptions,
        input  sw_load, sw_load_val,
        input  set_busy, clear_busy, irq_ack,
        output status_word, top, irq
    );

endinterface

// File: rtl/fpu_status_unit_irq_fsm.sv
// Interrupt request sequencer. Raises irq once per unmasked-exception
// episode; after an acknowledge it stays quiet until ES has dropped.
module fpu_exc_irq_fsm
    import fpu_status_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic es,
    input  logic irq_ack,
    output logic irq
);

    irq_state_e r_state;
    logic       r_irq;

    assign irq = r_irq;

    // State and registered irq; ES low beats irq_ack so a cleared episode always re-arms
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IRQ_IDLE;
            r_irq   <= 1'b0;
        end else begin
            case (r_state)
                IRQ_IDLE: begin
                    if (es) begin
                        r_state <= IRQ_ASSERT;
                        r_irq   <= 1'b1;
                    end
                end
                IRQ_ASSERT: begin
                    if (!es) begin
                        r_state <= IRQ_IDLE;
                        r_irq   <= 1'b0;
                    end else if (irq_ack) begin
                        r_state <= IRQ_WAIT_CLR;
                        r_irq   <= 1'b0;
                    end
                end
                IRQ_WAIT_CLR: begin
                    if (!es) begin
                        r_state <= IRQ_IDLE;
                    end
                    r_irq <= 1'b0;
                end
                default: begin
                    r_state <= IRQ_IDLE;
                    r_irq   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/fpu_status_unit.sv
// x87 status word: sticky exception flags, condition codes, stack-top
// pointer and busy bit, with a summary ES bit driving the interrupt FSM.
// MODE_387 adds the stack-fault flag and C1 push/pop direction.
module fpu_status_unit
    import fpu_status_pkg::*;
#(
    parameter int PTR_W    = 3,
    parameter bit MODE_387 = 1'b0
) (
    input  logic               clk,
    input  logic               reset_n,
    fpu_status_unit_if.slave   bus
);

    localparam int SW_W   = 13 + PTR_W;
    localparam int C3_POS = sw_c3_pos(PTR_W);
    localparam int B_POS  = sw_b_pos(PTR_W);

    logic [EXC_N-1:0] r_flags;
    logic             r_sf;
    logic [3:0]       r_cc;      // {C3,C2,C1,C0}
    logic [PTR_W-1:0] r_top;
    logic             r_busy;

    logic             w_es;
    logic             w_sf;
    logic             w_stack_fault;
    logic             w_irq;
    logic [3:0]       w_cc_restore;
    logic [PTR_W-1:0] w_top_restore;
    logic             w_unused_sw_bits;

    assign w_stack_fault = bus.exc_valid & bus.stack_fault_in;
    assign w_es          = |(r_flags & ~bus.ctrl_mask);
    assign w_sf          = MODE_387 ? r_sf : 1'b0;

    assign w_cc_restore  = {bus.sw_load_val[C3_POS], bus.sw_load_val[SW_C2],
                            bus.sw_load_val[SW_C1],  bus.sw_load_val[SW_C0]};
    assign w_top_restore = bus.sw_load_val[SW_TOP_LSB +: PTR_W];

    // A restored image carries B and ES, but both are owned locally
    assign w_unused_sw_bits = &{1'b0, bus.sw_load_val[B_POS], bus.sw_load_val[SW_ES]};

    // Sticky exception flags and SF: restore, then clear, then accumulate
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_flags <= '0;
            r_sf    <= 1'b0;
        end else if (bus.sw_load) begin
            r_flags <= bus.sw_load_val[SW_PE:SW_IE];
            r_sf    <= MODE_387 ? bus.sw_load_val[SW_SF] : 1'b0;
        end else if (bus.clear_exceptions) begin
            r_flags <= '0;
            r_sf    <= 1'b0;
        end else if (bus.exc_valid) begin
            r_flags <= r_flags | bus.exc_in | {{(EXC_N-1){1'b0}}, bus.stack_fault_in};
            r_sf    <= r_sf | (MODE_387 & bus.stack_fault_in);
        end
    end

    // Condition codes; on a 387 a stack fault records its direction in C1
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cc <= '0;
        end else if (bus.sw_load) begin
            r_cc <= w_cc_restore;
        end else begin
            if (bus.cc_write) begin
                r_cc <= bus.cc_in;
            end
            if (MODE_387 && w_stack_fault) begin
                r_cc[1] <= bus.sf_overflow;
            end
        end
    end

    // Stack-top pointer, wrapping modulo the stack depth
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_top <= '0;
        end else if (bus.sw_load) begin
            r_top <= w_top_restore;
        end else if (bus.top_load) begin
            r_top <= bus.top_load_val;
        end else if (bus.top_inc && !bus.top_dec) begin
            r_top <= r_top + PTR_W'(1);
        end else if (bus.top_dec && !bus.top_inc) begin
            r_top <= r_top - PTR_W'(1);
        end
    end

    // Busy bit; clear dominates set
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy <= 1'b0;
        end else if (bus.clear_busy) begin
            r_busy <= 1'b0;
        end else if (bus.set_busy) begin
            r_busy <= 1'b1;
        end
    end

    fpu_exc_irq_fsm u_irq_fsm (
        .clk     (clk),
        .reset_n (reset_n),
        .es      (w_es),
        .irq_ack (bus.irq_ack),
        .irq     (w_irq)
    );

    assign bus.status_word = {r_busy, r_cc[3], r_top, r_cc[2], r_cc[1], r_cc[0],
                              w_es, w_sf, r_flags};
    assign bus.top         = r_top;
    assign bus.irq         = w_irq;

endmodule

// File: tb/tb_fpu_status_unit.sv
// Directed bench for the FPU status unit. Three builds share one stimulus:
// A = 387 semantics / 8-entry stack, B = 8087 / 8-entry, C = 8087 / 16-entry.
module tb_fpu_status_unit;

    logic       clk = 1'b0;
    logic       reset_n;

    logic       top_inc, top_dec, top_load;
    logic [2:0] top_load_val;
    logic       cc_write;
    logic [3:0] cc_in;
    logic       exc_valid;
    logic [5:0] exc_in;
    logic       stack_fault_in, sf_overflow;
    logic [5:0] ctrl_mask;
    logic       clear_exceptions;
    logic       sw_load;
    logic [15:0] sw_load_val;
    logic       set_busy, clear_busy, irq_ack;

    int n_vec = 0;
    int n_err = 0;

    fpu_status_unit_if #(.PTR_W(3)) if_a ();
    fpu_status_unit_if #(.PTR_W(3)) if_b ();
    fpu_status_unit_if #(.PTR_W(4)) if_c ();

    fpu_status_unit #(.PTR_W(3), .MODE_387(1'b1)) u_dut_387 (
        .clk(clk), .reset_n(reset_n), .bus(if_a));
    fpu_status_unit #(.PTR_W(3), .MODE_387(1'b0)) u_dut_8087 (
        .clk(clk), .reset_n(reset_n), .bus(if_b));
    fpu_status_unit #(.PTR_W(4), .MODE_387(1'b0)) u_dut_wide (
        .clk(clk), .reset_n(reset_n), .bus(if_c));

    assign if_a.top_inc = top_inc;            assign if_b.top_inc = top_inc;
    assign if_a.top_dec = top_dec;            assign if_b.top_dec = top_dec;
    assign if_a.top_load = top_load;          assign if_b.top_load = top_load;
    assign if_a.top_load_val = top_load_val;  assign if_b.top_load_val = top_load_val;
    assign if_a.cc_write = cc_write;          assign if_b.cc_write = cc_write;
    assign if_a.cc_in = cc_in;                assign if_b.cc_in = cc_in;
    assign if_a.exc_valid = exc_valid;        assign if_b.exc_valid = exc_valid;
    assign if_a.exc_in = exc_in;              assign if_b.exc_in = exc_in;
    assign if_a.stack_fault_in = stack_fault_in; assign if_b.stack_fault_in = stack_fault_in;
    assign if_a.sf_overflow = sf_overflow;    assign if_b.sf_overflow = sf_overflow;
    assign if_a.ctrl_mask = ctrl_mask;        assign if_b.ctrl_mask = ctrl_mask;
    assign if_a.clear_exceptions = clear_exceptions; assign if_b.clear_exceptions = clear_exceptions;
    assign if_a.sw_load = sw_load;            assign if_b.sw_load = sw_load;
    assign if_a.sw_load_val = sw_load_val;    assign if_b.sw_load_val = sw_load_val;
    assign if_a.set_busy = set_busy;          assign if_b.set_busy = set_busy;
    assign if_a.clear_busy = clear_busy;      assign if_b.clear_busy = clear_busy;
    assign if_a.irq_ack = irq_ack;            assign if_b.irq_ack = irq_ack;

    // The wide build only sees pointer stepping
    assign if_c.top_inc = top_inc;
    assign if_c.top_dec = top_dec;
    assign if_c.top_load = 1'b0;
    assign if_c.top_load_val = 4'h0;
    assign if_c.cc_write = 1'b0;
    assign if_c.cc_in = 4'h0;
    assign if_c.exc_valid = 1'b0;
    assign if_c.exc_in = 6'h00;
    assign if_c.stack_fault_in = 1'b0;
    assign if_c.sf_overflow = 1'b0;
    assign if_c.ctrl_mask = 6'h3F;
    assign if_c.clear_exceptions = 1'b0;
    assign if_c.sw_load = 1'b0;
    assign if_c.sw_load_val = 17'h0;
    assign if_c.set_busy = 1'b0;
    assign if_c.clear_busy = 1'b0;
    assign if_c.irq_ack = 1'b0;

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        top_inc = 0; top_dec = 0; top_load = 0; top_load_val = 3'd0;
        cc_write = 0; cc_in = 4'h0; exc_valid = 0; exc_in = 6'h00;
        stack_fault_in = 0; sf_overflow = 0; clear_exceptions = 0;
        sw_load = 0; sw_load_val = 16'h0; set_busy = 0; clear_busy = 0; irq_ack = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        ctrl_mask = 6'h3F;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_sw_a", if_a.status_word, 17'h0);
        check_val("rst_irq_a", if_a.irq, 17'h0);
        check_val("rst_top_c", if_c.top, 17'h0);
        reset_n = 1'b1;

        // Masked invalid-operation: flag set, no summary, no interrupt
        exc_valid = 1; exc_in = 6'h01;
        tick();
        idle_inputs();
        check_val("masked_ie_a", if_a.status_word, 17'h0001);
        check_val("masked_ie_b", if_b.status_word, 17'h0001);
        tick(); tick();
        check_val("masked_noirq", if_a.irq, 17'h0);
        clear_exceptions = 1;
        tick();
        idle_inputs();
        check_val("fclex", if_a.status_word, 17'h0);

        // Unmasked zero-divide: ES next cycle, irq the cycle after
        ctrl_mask = 6'h00;
        exc_valid = 1; exc_in = 6'h04;
        tick();
        idle_inputs();
        check_val("ze_es", if_a.status_word, 17'h0084);
        check_val("ze_irq_n1", if_a.irq, 17'h0);
        tick();
        check_val("ze_irq_n2", if_a.irq, 17'h1);
        irq_ack = 1;
        tick();
        idle_inputs();
        check_val("ack_drop", if_a.irq, 17'h0);
        exc_valid = 1; exc_in = 6'h01;
        tick();
        idle_inputs();
        tick();
        check_val("waitclr_hold", if_a.irq, 17'h0);
        clear_exceptions = 1;
        tick();
        idle_inputs();
        check_val("clr_low_byte", {9'h0, if_a.status_word[7:0]}, 17'h0);
        exc_valid = 1; exc_in = 6'h02;
        tick();
        idle_inputs();
        check_val("rearm_n1", if_a.irq, 17'h0);
        tick();
        check_val("rearm_n2", if_a.irq, 17'h1);

        // Masking everything while asserted drops irq
        ctrl_mask = 6'h3F;
        tick();
        check_val("mask_drop", if_a.irq, 17'h0);
        check_val("mask_es0", if_a.status_word, 17'h0002);
        ctrl_mask = 6'h00;
        tick();
        check_val("unmask_irq", if_a.irq, 17'h1);
        // ES low and ack together: must return to IDLE, not WAIT_CLR
        irq_ack = 1; ctrl_mask = 6'h3F;
        tick();
        idle_inputs();
        check_val("es_over_ack", if_a.irq, 17'h0);
        ctrl_mask = 6'h00;
        tick();
        check_val("idle_after_prec", if_a.irq, 17'h1);
        clear_exceptions = 1;
        tick();
        idle_inputs();
        tick();
        check_val("clr_irq_off", if_a.irq, 17'h0);
        check_val("clr_sw", if_a.status_word, 17'h0);

        // Top pointer wrap and priority
        top_dec = 1;
        tick();
        idle_inputs();
        check_val("dec_wrap_a", if_a.top, 17'd7);
        check_val("dec_wrap_c", if_c.top, 17'd15);
        top_inc = 1;
        tick();
        check_val("inc_wrap_a", if_a.top, 17'd0);
        check_val("inc_wrap_c", if_c.top, 17'd0);
        repeat (7) tick();
        idle_inputs();
        check_val("inc8_a", if_a.top, 17'd7);
        check_val("inc8_c", if_c.top, 17'd7);
        top_inc = 1; top_dec = 1;
        tick();
        idle_inputs();
        check_val("inc_dec", if_a.top, 17'd7);
        top_load = 1; top_load_val = 3'd5; top_inc = 1;
        tick();
        idle_inputs();
        check_val("load_over_inc", if_a.top, 17'd5);
        check_val("load_b", if_b.top, 17'd5);

        // Stack faults with a simultaneous condition-code write
        ctrl_mask = 6'h3F;
        exc_valid = 1; stack_fault_in = 1; sf_overflow = 1; cc_write = 1; cc_in = 4'h0;
        tick();
        check_val("sf_ovf_387", if_a.status_word, 17'h2A41);
        check_val("sf_ovf_8087", if_b.status_word, 17'h2801);
        sf_overflow = 0; cc_in = 4'hF;
        tick();
        idle_inputs();
        check_val("sf_unf_387", if_a.status_word, 17'h6D41);
        check_val("sf_unf_8087", if_b.status_word, 17'h6F01);
        check_val("sf_masked_irq", if_a.irq, 17'h0);
        clear_exceptions = 1; cc_write = 1; cc_in = 4'h0;
        tick();
        idle_inputs();
        check_val("sf_cleanup", if_a.status_word, 17'h2800);

        // Restore beats clear; B ignored, ES recomputed
        ctrl_mask = 6'h00;
        sw_load = 1; sw_load_val = 16'hFFFF; clear_exceptions = 1;
        tick();
        idle_inputs();
        check_val("restore_387", if_a.status_word, 17'h7FFF);
        check_val("restore_8087", if_b.status_word, 17'h7FBF);
        check_val("restore_top", if_a.top, 17'd7);
        tick();
        check_val("restore_irq", if_a.irq, 17'h1);
        set_busy = 1;
        tick();
        idle_inputs();
        check_val("busy_set", if_a.status_word, 17'hFFFF);
        set_busy = 1; clear_busy = 1;
        tick();
        idle_inputs();
        check_val("busy_clr_wins", if_a.status_word, 17'h7FFF);
        check_val("pre_rst_irq", if_a.irq, 17'h1);

        // Asynchronous reset in mid-cycle
        #3;
        reset_n = 1'b0;
        #1;
        check_val("arst_irq", if_a.irq, 17'h0);
        check_val("arst_sw_a", if_a.status_word, 17'h0);
        check_val("arst_sw_b", if_b.status_word, 17'h0);
        #2;
        reset_n = 1'b1;
        tick();
        check_val("post_rst_sw", if_a.status_word, 17'h0);

        // Restore outranks cc_write and top_load in the same cycle
        sw_load = 1; sw_load_val = 16'h1234; cc_write = 1; cc_in = 4'hF;
        top_load = 1; top_load_val = 3'd6; top_inc = 1;
        tick();
        idle_inputs();
        check_val("restore_prio_a", if_a.status_word, 17'h12B4);
        check_val("restore_prio_b", if_b.status_word, 17'h12B4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fpu_status_unit.md
FPU_STATUS_UNIT -- requirements
Module: fpu_status_unit

Interface
REQ-001 Parameter PTR_W, default 3, sets the register-stack pointer width; stack depth is 2^PTR_W.
REQ-002 Parameter MODE_387, default 0: 0 gives 8087 semantics (bit 6 reads 0); 1 gives 387 semantics (stack-fault bit and C1 direction implemented).
REQ-003 Parameter SW_W = 13+PTR_W (derived, not overridable) is the status word width.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 top_inc / top_dec  in  1 each  pop / push adjustments of the top pointer.
REQ-007 top_load  in  1, top_load_val  in  PTR_W  direct top-pointer load.
REQ-008 cc_write  in  1, cc_in  in  4  {C3,C2,C1,C0} condition-code write.
REQ-009 exc_valid  in  1, exc_in  in  6  {PE,UE,OE,ZE,DE,IE}, sampled only when exc_valid=1.
REQ-010 stack_fault_in  in  1, sf_overflow  in  1  stack fault qualifier (1 = push overflow, 0 = pop underflow), sampled with exc_valid.
REQ-011 ctrl_mask  in  6  exception masks from the control word, same bit order as exc_in.
REQ-012 clear_exceptions  in  1  FCLEX/FINIT flag clear.
REQ-013 sw_load  in  1, sw_load_val  in  SW_W  FLDENV/FRSTOR status restore.
REQ-014 set_busy / clear_busy  in  1 each  busy control.
REQ-015 irq_ack  in  1  interrupt acknowledge from the CPU interface.
REQ-016 status_word  out  SW_W  {B, C3, TOP, C2, C1, C0, ES, SF, PE, UE, OE, ZE, DE, IE}, MSB first.
REQ-017 top  out  PTR_W  current top-of-stack pointer.
REQ-018 irq  out  1  registered interrupt request (8087 INT).

Function
REQ-019 Exception flags are sticky; exc_valid=1 ORs exc_in into the flags one cycle later.
REQ-020 Flag-update priority: sw_load > clear_exceptions > accumulation.
REQ-021 When stack_fault_in=1 and exc_valid=1, IE is set.
REQ-022 When MODE_387=1, a stack fault (REQ-021) also sets SF and writes C1 <= sf_overflow, overriding cc_in[1] in the same cycle.
REQ-023 When MODE_387=0, SF always reads 0 and stack faults do not modify C1.
REQ-024 ES is combinational: ES = |(flags & ~ctrl_mask).
REQ-025 cc_write=1 loads C3..C0 from cc_in next cycle; sw_load has priority over cc_write.
REQ-026 Top-pointer priority: sw_load > top_load > inc/dec; inc and dec together leave the pointer unchanged.
REQ-027 Top-pointer arithmetic is modulo 2^PTR_W: 0 decremented gives 2^PTR_W-1, and the maximum incremented gives 0.
REQ-028 sw_load loads C3..C0, TOP and the six flags (plus SF when MODE_387=1); the loaded B and ES bits are ignored, and ES is recomputed per REQ-024.
REQ-029 Busy: set_busy sets B and clear_busy clears B; clear wins when both are asserted.
REQ-030 The IRQ FSM has three states: IDLE, ASSERT, WAIT_CLR; irq=1 only in ASSERT.
REQ-031 IDLE->ASSERT when ES=1, so irq rises two cycles after the exc_valid that raises an unmasked flag.
REQ-032 ASSERT->WAIT_CLR on irq_ack.
REQ-033 From ASSERT or WAIT_CLR, the FSM returns to IDLE when ES=0 (via clear_exceptions, sw_load or unmasking); ES=0 takes precedence over irq_ack in the same cycle.
REQ-034 A new exception while in WAIT_CLR does not re-raise irq until the FSM has passed through IDLE.
REQ-035 Masking all exceptions in ASSERT drops irq the next cycle (the FSM goes to IDLE).

Reset
REQ-036 reset_n=0 immediately clears B, C3..C0, TOP, all flags and irq, and forces the FSM to IDLE, including mid-operation; status_word then reads 0.
REQ-037 The first state update occurs on the first clk edge after reset_n deasserts.

Structure
REQ-038 A shared package fpu_status_pkg holds the exception bit-index constants, the status-word field positions and the FSM state encoding.
REQ-039 The IRQ FSM is one sub-module, fpu_exc_irq_fsm (inputs es and irq_ack; output irq); all other logic is flat.

Verification
REQ-040 Masks=6'h3F, exc_valid with exc_in=6'h01 -> IE=1, ES=0, irq stays 0; status_word=16'h0001.
REQ-041 Masks=0, exc_in=6'h04 at cycle N -> ES=1 at N+1, irq=1 at N+2; irq_ack -> irq=0; clear_exceptions -> FSM IDLE, status_word[7:0]=0.
REQ-042 TOP=0, top_dec -> TOP=7; top_inc ×8 -> TOP=7; inc and dec together -> unchanged; PTR_W=4 build wraps 0->15.
REQ-043 MODE_387=1, stack_fault_in=1, sf_overflow=1, cc_write with cc_in=0 in the same cycle -> SF=1, IE=1, C1=1; MODE_387=0 build gives SF=0, C1=0.
REQ-044 sw_load with 16'hFFFF -> status_word=16'h7FFF (B ignored, ES recomputed as 1 with masks=0); clear_exceptions in the same cycle is ignored.
REQ-045 irq=1, assert reset_n=0 mid-cycle -> irq and status_word go to 0 asynchronously; set_busy with clear_busy -> B=0.
